alto_writable_control_store: RTL and testbench
==============================================

ALTO_WRITABLE_CONTROL_STORE -- requirements
Module: alto_writable_control_store

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, microstore address width (depth 2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 32, microinstruction width; even, >= 2.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port initializing_i  input  1  forces fetched microinstruction to zero (NOP).
REQ-006 SHALL have port mpc_i  input  ADDR_W  fetch address.
REQ-007 SHALL have port instruction_o  output  DATA_W  registered fetched microinstruction.
REQ-008 SHALL have port busy_o  output  1  high while the post-reset fill runs.
REQ-009 SHALL have port wr_req_i  input  1  write request, single-cycle pulse or held.
REQ-010 SHALL have port wr_addr_i  input  ADDR_W  write address.
REQ-011 SHALL have port wr_data_i  input  DATA_W  write data.
REQ-012 SHALL have port wr_ack_o  output  1  one-cycle write completion pulse.
REQ-013 SHALL have port rd_req_i  input  1  readback request.
REQ-014 SHALL have port rd_addr_i  input  ADDR_W  readback address.
REQ-015 SHALL have port rd_high_i  input  1  readback half select: 1 = bits DATA_W-1:DATA_W/2, 0 = low half.
REQ-016 SHALL have port rd_data_o  output  DATA_W/2  readback half-word, held until next readback.
REQ-017 SHALL have port rd_valid_o  output  1  one-cycle pulse marking rd_data_o valid.

Function
REQ-018 SHALL be a FSM with states FILL, IDLE, WRITE, READ1, READ2.
REQ-019 FILL SHALL write word i with value i zero-extended to DATA_W, one word per cycle, i = 0 .. 2^ADDR_W-1, then enter IDLE; busy_o high exactly 2^ADDR_W cycles.
REQ-020 In FILL, wr_req_i and rd_req_i SHALL be ignored (not queued); wr_ack_o and rd_valid_o stay low.
REQ-021 Fetch SHALL have one-cycle latency: instruction_o <= initializing_i | busy_o ? 0 : store[mpc_i], every cycle, independent of FSM state.
REQ-022 IDLE with wr_req_i SHALL capture addr/data, enter WRITE; WRITE commits word, pulses wr_ack_o, returns to IDLE (ack 2 cycles after request edge).
REQ-023 IDLE with rd_req_i and no wr_req_i SHALL capture addr/half, go READ1 (array read) then READ2 (rd_data_o updated, rd_valid_o pulsed), then IDLE.
REQ-024 Simultaneous wr_req_i and rd_req_i in IDLE: write SHALL win; read is dropped, requester must re-assert.
REQ-025 Requests arriving outside IDLE SHALL be ignored.
REQ-026 Readback of an address written earlier SHALL return the new data once wr_ack_o has pulsed.
REQ-027 Fetch of an address committed in WRITE the same cycle: behaviour per REQ-032.

Reset
REQ-028 rst_i high SHALL, next edge: state FILL, fill index 0, instruction_o 0, busy_o 1, wr_ack_o 0, rd_valid_o 0, rd_data_o 0.
REQ-029 rst_i asserted mid-WRITE or mid-READ SHALL abort it (no ack/valid pulse) and restart FILL; rst_i mid-FILL restarts fill at index 0.
REQ-030 Memory contents need not be cleared by rst_i itself; FILL rewrites every word.

Configuration
REQ-031 Macro WCS_FETCH_BYPASS_EN SHALL select write-to-fetch forwarding.
REQ-032 With WCS_FETCH_BYPASS_EN defined, a fetch with mpc_i equal to the address committed that cycle SHALL return new data; undefined, it SHALL return old data (read-before-write). initializing_i/busy_o zeroing applies in both.

Verification (ADDR_W=4, DATA_W=32)
REQ-033 rst_i 1 cycle -> busy_o high 16 cycles; then mpc_i=5 -> instruction_o=0x00000005 next cycle.
REQ-034 wr_req_i, wr_addr_i=3, wr_data_i=0xDEADBEEF -> wr_ack_o pulse 2 cycles later; fetch mpc_i=3 -> 0xDEADBEEF.
REQ-035 After REQ-034, rd_req_i, rd_addr_i=3, rd_high_i=1 -> rd_valid_o 3rd cycle, rd_data_o=0xDEAD; rd_high_i=0 -> 0xBEEF.
REQ-036 wr_req_i and rd_req_i same cycle in IDLE -> only wr_ack_o pulses, no rd_valid_o.
REQ-037 mpc_i=7 held while word 7 committed with 0x12345678 -> instruction_o 0x12345678 with bypass, 0x00000007 without, same cycle.
REQ-038 initializing_i=1, mpc_i=9 -> instruction_o=0; rst_i in READ1 -> no rd_valid_o, busy_o high next cycle.

Source files
------------

// File: rtl/alto_writable_control_store_if.sv
// Host-side write and readback channel of the writable control store.
// The host drives requests through master; the store responds through slave.
interface alto_writable_control_store_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  wr_req_i;
    logic [ADDR_W-1:0]     wr_addr_i;
    logic [DATA_W-1:0]     wr_data_i;
    logic                  wr_ack_o;
    logic                  rd_req_i;
    logic [ADDR_W-1:0]     rd_addr_i;
    logic                  rd_high_i;
    logic [DATA_W/2-1:0]   rd_data_o;
    logic                  rd_valid_o;

    modport master (
        output wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, rd_high_i,
        input  wr_ack_o, rd_data_o, rd_valid_o
    );

    modport slave (
        input  wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, rd_high_i,
        output wr_ack_o, rd_data_o, rd_valid_o
    );
endinterface

// File: rtl/alto_writable_control_store.sv
// Alto microcode store: self-fill after reset, registered fetch, host write and half-word readback.
// Latency: fetch 1 cycle, write ack 2 cycles, readback valid 3 cycles; WCS_FETCH_BYPASS_EN forwards writes to fetch.
// Backpressure: none; requests are sampled only in IDLE and dropped otherwise, so the host re-asserts.
module alto_writable_control_store #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 initializing_i,
    input  logic [ADDR_W-1:0]    mpc_i,
    output logic [DATA_W-1:0]    instruction_o,
    output logic                 busy_o,
    alto_writable_control_store_if.slave wcs
);
    localparam int HALF  = DATA_W / 2;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {S_FILL, S_IDLE, S_WRITE, S_READ1, S_READ2} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fill_idx_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                rd_high_q;
    logic [DATA_W-1:0]   rd_word_q;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                cap_wr, cap_rd, ack_d, vld_d;
    logic [DATA_W-1:0]   fetch_word, fetch_d;

    logic [DATA_W-1:0]   store [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_waddr = fill_idx_q;
        mem_wdata = DATA_W'(fill_idx_q);
        cap_wr    = 1'b0;
        cap_rd    = 1'b0;
        ack_d     = 1'b0;
        vld_d     = 1'b0;
        case (state_q)
            S_FILL: begin
                mem_we = 1'b1;
                if (fill_idx_q == {ADDR_W{1'b1}}) state_d = S_IDLE;
            end
            S_IDLE: begin
                // Write has priority; a concurrent read is dropped, not queued.
                if (wcs.wr_req_i) begin
                    cap_wr  = 1'b1;
                    state_d = S_WRITE;
                end else if (wcs.rd_req_i) begin
                    cap_rd  = 1'b1;
                    state_d = S_READ1;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_waddr = wr_addr_q;
                mem_wdata = wr_data_q;
                ack_d     = 1'b1;
                state_d   = S_IDLE;
            end
            S_READ1: state_d = S_READ2;
            S_READ2: begin
                vld_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_FILL;
        endcase
    end

    assign busy_o = (state_q == S_FILL);

    always_comb begin
        fetch_word = store[mpc_i];
`ifdef WCS_FETCH_BYPASS_EN
        if (mem_we && (mem_waddr == mpc_i)) fetch_word = mem_wdata;
`endif
        fetch_d = (initializing_i || busy_o) ? '0 : fetch_word;
    end

    // No reset on the array; FILL rewrites every word. Reset blocks an in-flight commit.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) store[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_idx_q     <= '0;
            instruction_o  <= '0;
            wcs.wr_ack_o   <= 1'b0;
            wcs.rd_valid_o <= 1'b0;
            wcs.rd_data_o  <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            rd_addr_q      <= '0;
            rd_high_q      <= 1'b0;
            rd_word_q      <= '0;
        end else begin
            if (state_q == S_FILL) fill_idx_q <= fill_idx_q + 1'b1;
            instruction_o  <= fetch_d;
            wcs.wr_ack_o   <= ack_d;
            wcs.rd_valid_o <= vld_d;
            if (cap_wr) begin
                wr_addr_q <= wcs.wr_addr_i;
                wr_data_q <= wcs.wr_data_i;
            end
            if (cap_rd) begin
                rd_addr_q <= wcs.rd_addr_i;
                rd_high_q <= wcs.rd_high_i;
            end
            if (state_q == S_READ1) rd_word_q <= store[rd_addr_q];
            if (state_q == S_READ2)
                wcs.rd_data_o <= rd_high_q ? rd_word_q[DATA_W-1:HALF] : rd_word_q[HALF-1:0];
        end
    end
endmodule

// File: tb/tb_alto_writable_control_store.sv
// Randomized bench for alto_writable_control_store (ADDR_W=4, DATA_W=32) against a word-array model.
module tb_alto_writable_control_store;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          initializing_i;
    logic [AW-1:0] mpc_i;
    logic [DW-1:0] instruction_o;
    logic          busy_o;

    alto_writable_control_store_if #(.ADDR_W(AW), .DATA_W(DW)) wcs ();

    alto_writable_control_store #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .initializing_i (initializing_i),
        .mpc_i          (mpc_i),
        .instruction_o  (instruction_o),
        .busy_o         (busy_o),
        .wcs            (wcs)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] model [16];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_fill();
        for (int i = 0; i < 16; i++) model[i] = DW'(i);
    endtask

    task automatic wait_fill();
        int cnt = 0;
        while (busy_o === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        check("busy_cycles", DW'(cnt), 32'd16);
        model_fill();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wcs.wr_req_i  = 1'b1;
        wcs.wr_addr_i = a;
        wcs.wr_data_i = d;
        tick();
        wcs.wr_req_i = 1'b0;
        check("wr_ack_early", DW'(wcs.wr_ack_o), 32'd0);
        tick();
        check("wr_ack_pulse", DW'(wcs.wr_ack_o), 32'd1);
        model[a] = d;
        tick();
        check("wr_ack_low", DW'(wcs.wr_ack_o), 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic hi);
        logic [DW-1:0] w;
        logic [DW/2-1:0] exp;
        w   = model[a];
        exp = hi ? w[DW-1:DW/2] : w[DW/2-1:0];
        wcs.rd_req_i  = 1'b1;
        wcs.rd_addr_i = a;
        wcs.rd_high_i = hi;
        tick();
        wcs.rd_req_i = 1'b0;
        check("rd_valid_c1", DW'(wcs.rd_valid_o), 32'd0);
        tick();
        check("rd_valid_c2", DW'(wcs.rd_valid_o), 32'd0);
        tick();
        check("rd_valid_c3", DW'(wcs.rd_valid_o), 32'd1);
        check("rd_data", DW'(wcs.rd_data_o), DW'(exp));
        tick();
        check("rd_valid_low", DW'(wcs.rd_valid_o), 32'd0);
        check("rd_data_held", DW'(wcs.rd_data_o), DW'(exp));
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, input logic init);
        mpc_i = a;
        initializing_i = init;
        tick();
        check("fetch", instruction_o, init ? '0 : model[a]);
        initializing_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        int vcnt;
        rst_i = 1'b1;
        initializing_i = 1'b0;
        mpc_i = '0;
        wcs.wr_req_i = 1'b0; wcs.wr_addr_i = '0; wcs.wr_data_i = '0;
        wcs.rd_req_i = 1'b0; wcs.rd_addr_i = '0; wcs.rd_high_i = 1'b0;
        tick();
        check("rst_instr", instruction_o, '0);
        check("rst_busy", DW'(busy_o), 32'd1);
        check("rst_ack", DW'(wcs.wr_ack_o), 32'd0);
        check("rst_valid", DW'(wcs.rd_valid_o), 32'd0);
        check("rst_rdata", DW'(wcs.rd_data_o), 32'd0);
        rst_i = 1'b0;
        // Requests during fill must be ignored.
        wcs.wr_req_i = 1'b1; wcs.rd_req_i = 1'b1; wcs.wr_addr_i = 4'd2; wcs.wr_data_i = 32'hFFFF_FFFF;
        tick();
        check("fill_ack_low", DW'(wcs.wr_ack_o), 32'd0);
        wcs.wr_req_i = 1'b0; wcs.rd_req_i = 1'b0;
        begin
            int cnt = 1;
            while (busy_o === 1'b1 && cnt < 100) begin
                check("fill_valid_low", DW'(wcs.rd_valid_o), 32'd0);
                cnt++;
                tick();
            end
            check("busy_cycles", DW'(cnt), 32'd16);
            model_fill();
        end

        do_fetch(4'd5, 1'b0);
        do_fetch(4'd2, 1'b0);

        do_write(4'd3, 32'hDEAD_BEEF);
        do_fetch(4'd3, 1'b0);
        do_read(4'd3, 1'b1);
        do_read(4'd3, 1'b0);

        // Write wins over a simultaneous read; a read request during WRITE is ignored.
        wcs.wr_req_i = 1'b1; wcs.wr_addr_i = 4'd10; wcs.wr_data_i = 32'hCAFE_0A0A;
        wcs.rd_req_i = 1'b1; wcs.rd_addr_i = 4'd10; wcs.rd_high_i = 1'b0;
        tick();
        wcs.wr_req_i = 1'b0;
        tick();
        check("both_ack", DW'(wcs.wr_ack_o), 32'd1);
        model[10] = 32'hCAFE_0A0A;
        wcs.rd_req_i = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wcs.rd_valid_o === 1'b1) vcnt++;
        end
        check("both_no_valid", DW'(vcnt), 32'd0);

        // Write-to-fetch same-cycle behaviour.
        mpc_i = 4'd7;
        wcs.wr_req_i = 1'b1; wcs.wr_addr_i = 4'd7; wcs.wr_data_i = 32'h1234_5678;
        tick();
        wcs.wr_req_i = 1'b0;
        tick();
        check("bypass_ack", DW'(wcs.wr_ack_o), 32'd1);
`ifdef WCS_FETCH_BYPASS_EN
        check("bypass_fetch", instruction_o, 32'h1234_5678);
`else
        check("bypass_fetch", instruction_o, 32'h0000_0007);
`endif
        model[7] = 32'h1234_5678;
        tick();
        check("post_commit_fetch", instruction_o, 32'h1234_5678);

        do_fetch(4'd9, 1'b1);

        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0) do_write(AW'($urandom_range(0, 15)), $urandom);
            else if (op == 1) do_read(AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            else do_fetch(AW'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end

        // Reset during READ1 aborts the readback and restarts fill.
        wcs.rd_req_i = 1'b1; wcs.rd_addr_i = 4'd3; wcs.rd_high_i = 1'b1;
        tick();
        wcs.rd_req_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rst_read_valid", DW'(wcs.rd_valid_o), 32'd0);
        check("rst_read_busy", DW'(busy_o), 32'd1);
        wait_fill();
        check("post_fill_valid", DW'(wcs.rd_valid_o), 32'd0);
        do_fetch(4'd3, 1'b0);
        do_fetch(4'd7, 1'b0);
        do_read(4'd15, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
